// File: rtl/cache_assoc.sv
// N-way set-associative write-back / write-allocate cache with LRU replacement.
// Optional access/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_assoc #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 4,
    parameter int WAYS       = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_read,
    input  logic                            req_write,
    input  logic [WORD_SIZE-1:0]            req_addr,
    input  logic [WORD_SIZE-1:0]            req_wdata,
    output logic [WORD_SIZE-1:0]            req_rdata,
    output logic                            req_ready,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [WORD_SIZE-1:0]            mem_addr,
    output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
    input  logic                            mem_ready,
    output logic [WORD_SIZE-1:0]            num_cache_access,
    output logic [WORD_SIZE-1:0]            num_cache_miss
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = WORD_SIZE - OFF - IDX;
    localparam int LINE  = WORD_SIZE * LINE_WORDS;
    localparam int IDX_W = (IDX > 0) ? IDX : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Request handshake: a request (req_read or req_write) is held until req_ready,
    // and completes on the rising edge where req_ready is high.
    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
    state_t state, state_next;

    logic [LINE-1:0]  data_q  [SETS][WAYS];
    logic [TAG-1:0]   tag_q   [SETS][WAYS];
    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];
    logic [WAY_W-1:0] victim_q;

    logic [IDX_W-1:0] set_idx;
    logic [TAG-1:0]   req_tag;
    logic [OFF-1:0]   word_off;
    logic             hit, found_invalid, lookup, miss, fill_done;
    logic [WAY_W-1:0] hit_way, victim;
    logic [LINE-1:0]  hit_line;

    assign word_off  = req_addr[OFF-1:0];
    assign req_tag   = req_addr[WORD_SIZE-1 -: TAG];
    assign set_idx   = IDX_W'((req_addr >> OFF) & WORD_SIZE'(SETS - 1));
    assign lookup    = (state == IDLE) && (req_read || req_write);
    assign req_ready = lookup && hit;
    assign miss      = lookup && !hit;
    assign fill_done = (state == REFILL) && mem_ready;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Ages are a permutation, so the LRU way is the one holding age WAYS-1.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                victim        = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        hit_line  = data_q[set_idx][hit_way];
        req_rdata = '0;
        if (req_ready && req_read) req_rdata = hit_line[int'(word_off)*WORD_SIZE +: WORD_SIZE];
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (miss) begin
                    if (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) state_next = WB;
                    else                                                      state_next = REFILL;
                end
            end
            WB: begin
                mem_write = 1'b1;
                mem_addr  = (WORD_SIZE'(tag_q[set_idx][victim_q]) << (OFF + IDX))
                          | (WORD_SIZE'(set_idx) << OFF);
                mem_wdata = data_q[set_idx][victim_q];
                if (mem_ready) state_next = REFILL;
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = req_addr & ~WORD_SIZE'(LINE_WORDS - 1);
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state <= state_next;
            if (miss) victim_q <= victim;
            if (req_ready) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)
                        age_q[set_idx][w] <= '0;
                    else if (age_q[set_idx][w] < age_q[set_idx][hit_way])
                        age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
                end
                if (req_write) dirty_q[set_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line payload and tags need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (req_ready && req_write)
            data_q[set_idx][hit_way][int'(word_off)*WORD_SIZE +: WORD_SIZE] <= req_wdata;
        if (fill_done) begin
            data_q[set_idx][victim_q] <= mem_rdata;
            tag_q[set_idx][victim_q]  <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cache_access <= '0;
            num_cache_miss   <= '0;
        end else begin
            if (req_ready) num_cache_access <= num_cache_access + 1'b1;
            if (miss)      num_cache_miss   <= num_cache_miss + 1'b1;
        end
    end
`else
    assign num_cache_access = '0;
    assign num_cache_miss   = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: directed scenarios plus random traffic checked against a
// per-set recency-list model of the cache and a word-level backing memory.
module tb_cache_assoc;
    localparam int W = 16, LW = 4, SETS = 4, WAYS = 2;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          req_read = 1'b0, req_write = 1'b0;
    logic [W-1:0]  req_addr = '0, req_wdata = '0, req_rdata;
    logic          req_ready, mem_read, mem_write, mem_ready = 1'b0;
    logic [W-1:0]  mem_addr;
    logic [W*LW-1:0] mem_wdata, mem_rdata = '0;
    logic [W-1:0]  num_cache_access, num_cache_miss;

    cache_assoc #(.WORD_SIZE(W), .LINE_WORDS(LW), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rdata(req_rdata), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .num_cache_access(num_cache_access), .num_cache_miss(num_cache_miss)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: each set holds WAYS slots and a recency list (MRU first).
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    logic [W-1:0] m_data [SETS][WAYS][LW];
    int          rec     [SETS][$];
    logic [W-1:0] mem_model [int];
    int          exp_acc, exp_miss;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mem_rd(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return W'(a * 37 + 11);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            rec[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                rec[s].push_back(w);
            end
        end
        exp_acc  = 0;
        exp_miss = 0;
    endfunction

    function automatic void touch(input int s, input int way);
        for (int i = 0; i < rec[s].size(); i++)
            if (rec[s][i] == way) begin rec[s].delete(i); break; end
        rec[s].push_front(way);
    endfunction

    task automatic check_counters();
        check("num_cache_access", num_cache_access, STATS ? W'(exp_acc) : '0);
        check("num_cache_miss",   num_cache_miss,   STATS ? W'(exp_miss) : '0);
    endtask

    // Waits for a memory request, checks it, then answers after 'delay' cycles.
    task automatic mem_txn(input bit is_wr, input logic [W-1:0] exp_addr,
                           input logic [W*LW-1:0] line, input int delay);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mem_read || mem_write) && n < 30);
        check(is_wr ? "mem_write_seen" : "mem_read_seen", is_wr ? mem_write : mem_read, 1);
        check("mem_rw_exclusive", mem_read & mem_write, 0);
        check(is_wr ? "wb_addr" : "refill_addr", mem_addr, exp_addr);
        if (is_wr) check("wb_data", mem_wdata, line);
        repeat (delay) @(negedge clk);
        #1;
        mem_rdata = is_wr ? '0 : line;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [W-1:0] addr, input logic [W-1:0] wd,
                          input int lat);
        int s, t, o, way;
        bit hit;
        logic [W*LW-1:0] line;
        s = (int'(addr) >> 2) % SETS;
        t = int'(addr) >> 4;
        o = int'(addr) % LW;
        way = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        hit = (way >= 0);

        @(negedge clk);
        req_read = !wr; req_write = wr; req_addr = addr; req_wdata = wd;
        #1;
        check("req_ready_lookup", req_ready, hit);
        if (!hit) begin
            exp_miss++;
            way = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
            if (way < 0) way = rec[s][$];
            if (m_valid[s][way] && m_dirty[s][way]) begin
                int base = (m_tag[s][way] << 4) | (s << 2);
                for (int k = 0; k < LW; k++) line[k*W +: W] = m_data[s][way][k];
                mem_txn(1'b1, W'(base), line, lat);
                for (int k = 0; k < LW; k++) mem_model[base + k] = m_data[s][way][k];
            end
            for (int k = 0; k < LW; k++) begin
                m_data[s][way][k] = mem_rd((int'(addr) & ~(LW - 1)) + k);
                line[k*W +: W]    = m_data[s][way][k];
            end
            mem_txn(1'b0, addr & ~W'(LW - 1), line, lat);
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = t;
            check("req_ready_after_fill", req_ready, 1);
        end else begin
            check("no_mem_on_hit", {mem_read, mem_write}, 0);
        end
        if (wr) begin
            m_data[s][way][o] = wd;
            m_dirty[s][way]   = 1'b1;
        end else begin
            check("req_rdata", req_rdata, m_data[s][way][o]);
        end
        touch(s, way);
        exp_acc++;
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        check_counters();
    endtask

    initial begin
        int n;
        model_reset();
        mem_model[16'h10] = 16'h00A0; mem_model[16'h11] = 16'h00A1;
        mem_model[16'h12] = 16'h00A2; mem_model[16'h13] = 16'h00A3;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check_counters();
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("idle_req_ready", req_ready, 0);
        check("idle_rdata", req_rdata, 0);

        // Cold miss, read hit, write hit, then dirty eviction from set 0
        do_req(1'b0, 16'h0012, '0, 3);
        do_req(1'b0, 16'h0013, '0, 3);
        do_req(1'b1, 16'h0011, 16'hBEEF, 1);
        do_req(1'b0, 16'h0050, '0, 0);
        do_req(1'b0, 16'h0090, '0, 2);
        do_req(1'b0, 16'h0011, '0, 1);

        // Reset during a refill drops mem_read at once and invalidates everything
        @(negedge clk);
        req_read = 1'b1; req_addr = 16'h0124;
        #1;
        check("rst_mid_miss_ready", req_ready, 0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!mem_read && n < 30);
        check("rst_mid_refill_active", mem_read, 1);
        reset_n = 1'b0;
        #1;
        check("rst_drops_mem_read", mem_read, 0);
        check("rst_drops_mem_write", mem_write, 0);
        req_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check_counters();

        // LRU order: 0x0050 becomes LRU and is replaced cleanly
        do_req(1'b0, 16'h0010, '0, 1);
        do_req(1'b0, 16'h0050, '0, 1);
        do_req(1'b0, 16'h0010, '0, 0);
        do_req(1'b0, 16'h0090, '0, 2);
        do_req(1'b0, 16'h0012, '0, 0);
        do_req(1'b0, 16'h0053, '0, 0);

        // Random mixed traffic over a small tag pool to force conflicts
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            a = W'(($urandom_range(0, 5) << 4) | ($urandom_range(0, SETS - 1) << 2)
                   | $urandom_range(0, LW - 1));
            do_req($urandom_range(0, 9) < 4, a, W'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between datapath and line-wide memory.
- Generalises the direct-mapped cache: configurable word width, line size, set count and associativity.
- Adds LRU replacement and dirty-line writeback, and uses separate in/out data buses instead of inout buses.
- Keeps access and miss statistics.

Parameters:
- WORD_SIZE, 16, datapath word and address width in bits. Addresses are word-addressed.
- LINE_WORDS, 4, words per line; power of two, >=2.
- SETS, 4, number of sets; power of two, >=1.
- WAYS, 2, associativity; power of two, 1..8.
- Derived: OFF=clog2(LINE_WORDS), IDX=clog2(SETS), TAG=WORD_SIZE-OFF-IDX.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read  in  1  datapath read request; held until req_ready.
- req_write  in  1  datapath write request; held until req_ready; mutually exclusive with req_read.
- req_addr  in  WORD_SIZE  word address.
- req_wdata  in  WORD_SIZE  store data.
- req_rdata  out  WORD_SIZE  load data; valid while req_ready && req_read.
- req_ready  out  1  request completes this cycle.
- mem_read  out  1  line refill request.
- mem_write  out  1  line writeback request.
- mem_addr  out  WORD_SIZE  line base address; low OFF bits are 0.
- mem_wdata  out  WORD_SIZE*LINE_WORDS  writeback line; word 0 in the LSBs.
- mem_rdata  in  WORD_SIZE*LINE_WORDS  refill line; sampled when mem_ready.
- mem_ready  in  1  one-cycle pulse: memory transaction complete.
- num_cache_access  out  WORD_SIZE  completed requests.
- num_cache_miss  out  WORD_SIZE  misses.

Behaviour:
- Reset values:
  - All valid and dirty bits 0; age of way w = w.
  - FSM in IDLE.
  - All outputs 0, including both counters.
- States:
  - IDLE: on a request, compare tag against all ways of set req_addr[OFF+IDX-1:OFF].
    - Hit: req_ready=1 combinationally in the same cycle; req_rdata = hit word.
    - Write hit: word and dirty=1 updated at that edge.
    - Miss: select victim (see below). Victim valid && dirty -> WB; else -> REFILL.
    - Miss gives req_ready=0.
  - WB: mem_write=1, mem_addr={victim tag,index,0}, mem_wdata=victim line, all held until mem_ready. On mem_ready -> REFILL.
  - REFILL: mem_read=1, mem_addr={req tag,index,0}, held until mem_ready. On mem_ready: victim line <= mem_rdata, tag written, valid=1, dirty=0 -> IDLE.
  - Back in IDLE the held request hits (miss latency = memory time + 1 cycle).
- mem_read and mem_write are never both high. mem_ready outside WB/REFILL is ignored.
- Victim selection: lowest-indexed invalid way if any exists; otherwise the way with the maximum age.
- LRU:
  - On every hit (including the post-refill hit), the accessed way's age becomes 0.
  - Ways with age < the old age of the accessed way increment by 1; others are unchanged.
  - Ages stay a permutation of 0..WAYS-1. WAYS=1: no age storage; way 0 is always the victim.
- Counters:
  - num_cache_access +1 on each cycle with req_ready=1.
  - num_cache_miss +1 on each IDLE->WB or IDLE->REFILL transition.
  - Both wrap modulo 2^WORD_SIZE.
- req_addr, req_read and req_write changing mid-miss is a protocol violation; behaviour is undefined.
- Reset asserted mid-WB/REFILL: mem_read and mem_write drop immediately (asynchronously), the line is lost, and the FSM goes to IDLE.
- No request in IDLE: cache state and counters are unchanged.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: num_cache_access and num_cache_miss count as above.
- Undefined: both outputs are constant 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Cold read miss: reset; req_read addr 0x0012; mem_ready 3 cycles after mem_read rises, mem_rdata words {0xA0,0xA1,0xA2,0xA3}.
  - Expect mem_addr=0x0010, then req_ready with req_rdata=0xA2.
  - Expect access=1, miss=1.
- Read hit: next req_read 0x0013 -> req_ready in the same cycle, rdata=0xA3, no mem_read; access=2, miss=1.
- Write hit then evict (WAYS=2, SETS=4):
  - req_write 0x0011 data 0xBEEF hits.
  - Read misses 0x0050 and 0x0090 (same set 0) force eviction of the 0x0010 line.
  - Expect mem_write with mem_addr=0x0010 and word1=0xBEEF, followed by mem_read 0x0090.
- LRU order: fill 0x0010 and 0x0050; hit 0x0010; miss 0x0090 -> 0x0050's way is replaced (clean line, no mem_write); a re-read of 0x0010 hits.
- Reset mid-refill: drop reset_n while mem_read=1 -> mem_read=0 the same cycle; after release all lookups miss and counters read 0.
- Stats off: compile without CACHE_STATS_EN and rerun the first scenario -> identical data and memory traffic, counters stay 0.
